// File: rtl/regfile_cmd_pkg.sv
// Shared definitions for the register-file command front-end: opcodes, FSM states
// and the bytes-per-word derivation.
package regfile_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_READ  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WRITE,
        READ,
        WAIT_RD,
        SEND
    } state_t;

    function automatic int nb_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/regfile_cmd_ser.sv
// Word-to-byte response serializer: loads a word, then presents it LSB byte first
// on a valid/ready stream, pulsing done_o when the last byte is taken.
module regfile_cmd_ser
    import regfile_cmd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             done_o
);

    localparam int NB = nb_of(WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_o  = 1'b0;
        if (load_i) begin
            word_d  = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            // Shift so the byte on data_o always comes straight from a register.
            word_d = word_q >> 8;
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                valid_d = 1'b0;
                done_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = word_q[7:0];
    assign valid_o = valid_q;

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Byte-stream command decoder/FSM driving the register file strobes, address and data.
// Optional: define REGFILE_CMD_ADDR_CHECK_EN to reject address bytes with upper bits set.
module regfile_cmd_ctrl
    import regfile_cmd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rf_wr_en,
    output logic             rf_rd_en,
    output logic [ADDR-1:0]  rf_address,
    output logic [WIDTH-1:0] rf_wr_data,
    input  logic [WIDTH-1:0] rf_rd_data,
    output logic             busy,
    output logic             err
);

    localparam int NB = nb_of(WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_t           state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic             bad_q, bad_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             in_ready_q, wr_en_q, rd_en_q, busy_q;
    logic             accept, addr_bad;
    logic             ser_load, ser_done;
    logic [WIDTH-1:0] ser_word;

    assign accept = in_valid && in_ready_q;

`ifdef REGFILE_CMD_ADDR_CHECK_EN
    assign addr_bad = ((in_data >> ADDR) != 8'h00);
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        ser_load = 1'b0;
        ser_word = rf_rd_data;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data == OP_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (in_data == OP_READ) begin
                        is_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (accept) begin
                    addr_d = in_data[ADDR-1:0];
                    cnt_d  = '0;
                    bad_d  = addr_bad;
                    err_d  = addr_bad;
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else if (addr_bad) begin
                        // Rejected read answers with an all-zero word, no register access.
                        ser_load = 1'b1;
                        ser_word = '0;
                        state_d  = SEND;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            GET_DATA: begin
                if (accept) begin
                    wdata_d[8*cnt_q +: 8] = in_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = bad_q ? IDLE : WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = WAIT_RD;
            WAIT_RD: begin
                ser_load = 1'b1;
                cnt_d    = '0;
                state_d  = SEND;
            end
            SEND: begin
                if (ser_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshake outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            bad_q      <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            bad_q      <= bad_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_DATA);
            wr_en_q    <= (state_d == WRITE);
            rd_en_q    <= (state_d == READ);
            busy_q     <= (state_d != IDLE);
        end
    end

    regfile_cmd_ser #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (ser_load),
        .word_i  (ser_word),
        .ready_i (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .done_o  (ser_done)
    );

    assign in_ready   = in_ready_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_rd_en   = rd_en_q;
    assign rf_address = addr_q;
    assign rf_wr_data = wdata_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
